screen_feeder: RTL



---
 rtl/screen_feeder_pkg.sv | 33 +++
 rtl/feeder_delay_timer.sv | 28 ++
 rtl/screen_feeder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/screen_feeder_pkg.sv
// Shared types and constants for the static-screen feeder.
package screen_feeder_pkg;

    localparam int unsigned ROM_DW  = 10;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned PIX_W   = 16;
    localparam int unsigned DLY_BIT = 9;
    localparam int unsigned DC_BIT  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROM_RD = 3'd1,
        ST_DELAY  = 3'd2,
        ST_SEND   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_PIX_RD = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT   = 2'd0,
        PH_PIX_HI = 2'd1,
        PH_PIX_LO = 2'd2
    } phase_t;

    // Init ROM word: delay flag, dc, then command/data byte or delay units.
    typedef struct packed {
        logic              dly;
        logic              dc;
        logic [BYTE_W-1:0] val;
    } rom_word_t;

endpackage

// File: rtl/feeder_delay_timer.sv
// Loadable down-counter used for init-sequence delays; o_zero_c flags expiry.
module feeder_delay_timer #(
    parameter int unsigned CW = 24
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_value,
    input  logic          i_dec,
    output logic          o_zero_c
);

    logic [CW-1:0] r_cnt;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/screen_feeder.sv
// Sequencer feeding the SPI sender: init ROM walk, then one RGB565 frame as byte pairs.
// Build option: SCREEN_FEEDER_REFRESH_EN makes the frame repeat forever after one init.
module screen_feeder
    import screen_feeder_pkg::*;
#(
    parameter int unsigned INIT_LEN  = 32,
    parameter int unsigned ROM_AW    = 5,
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned HEIGHT    = 160,
    parameter int unsigned PIX_AW    = 15,
    parameter int unsigned DELAY_CYC = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [ROM_DW-1:0] i_rom_data,
    output logic [PIX_AW-1:0] o_pix_addr,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic [BYTE_W-1:0] o_spi_data,
    output logic              o_spi_dc,
    output logic              o_spi_init,
    input  logic              i_spi_done
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned CW   = $clog2(255 * DELAY_CYC + 1);

    state_t             r_state,      w_state_nxt;
    phase_t             r_phase,      w_phase_nxt;
    logic [ROM_AW-1:0]  r_rom_addr,   w_rom_addr_nxt;
    logic [PIX_AW-1:0]  r_pix_addr,   w_pix_addr_nxt;
    logic [BYTE_W-1:0]  r_pix_lo,     w_pix_lo_nxt;
    logic [BYTE_W-1:0]  r_spi_data,   w_spi_data_nxt;
    logic               r_spi_dc,     w_spi_dc_nxt;
    logic               r_spi_init,   w_spi_init_nxt;
    logic               r_busy,       w_busy_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_armed,      w_armed_nxt;
    logic [1:0]         r_done_sync;

    logic               w_done_s;
    rom_word_t          w_rom;
    logic               w_tmr_load;
    logic               w_tmr_dec;
    logic [CW-1:0]      w_tmr_value;
    logic               w_tmr_zero;

    assign w_rom    = rom_word_t'(i_rom_data);
    assign w_done_s = r_done_sync[1];

    feeder_delay_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_tmr_load),
        .i_value  (w_tmr_value),
        .i_dec    (w_tmr_dec),
        .o_zero_c (w_tmr_zero)
    );

    // Bring the sender's done level into this clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done_sync <= 2'b00;
        end else begin
            r_done_sync <= {r_done_sync[0], i_spi_done};
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_INIT;
            r_rom_addr   <= '0;
            r_pix_addr   <= '0;
            r_pix_lo     <= '0;
            r_spi_data   <= '0;
            r_spi_dc     <= 1'b0;
            r_spi_init   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_rom_addr   <= w_rom_addr_nxt;
            r_pix_addr   <= w_pix_addr_nxt;
            r_pix_lo     <= w_pix_lo_nxt;
            r_spi_data   <= w_spi_data_nxt;
            r_spi_dc     <= w_spi_dc_nxt;
            r_spi_init   <= w_spi_init_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_armed      <= w_armed_nxt;
        end
    end

    // Next-state and next-output logic; r_armed records that done_s was seen
    // high after spi_init rose, so only a later 1->0 counts as acceptance.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_rom_addr_nxt   = r_rom_addr;
        w_pix_addr_nxt   = r_pix_addr;
        w_pix_lo_nxt     = r_pix_lo;
        w_spi_data_nxt   = r_spi_data;
        w_spi_dc_nxt     = r_spi_dc;
        w_spi_init_nxt   = r_spi_init;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;
        w_armed_nxt      = r_armed;
        w_tmr_load       = 1'b0;
        w_tmr_dec        = 1'b0;
        w_tmr_value      = '0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = ST_ROM_RD;
                    w_phase_nxt    = PH_INIT;
                    w_rom_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_ROM_RD: begin
                if (w_rom.dly) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = CW'(w_rom.val) * CW'(DELAY_CYC);
                    w_state_nxt = ST_DELAY;
                end else begin
                    w_spi_data_nxt = w_rom.val;
                    w_spi_dc_nxt   = w_rom.dc;
                    w_spi_init_nxt = 1'b1;
                    w_armed_nxt    = 1'b0;
                    w_state_nxt    = ST_SEND;
                end
            end
            ST_DELAY: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_armed && !w_done_s) begin
                    w_spi_init_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT;
                end else if (w_done_s) begin
                    w_armed_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_done_s) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                case (r_phase)
                    PH_INIT: begin
                        if (r_rom_addr == ROM_AW'(INIT_LEN - 1)) begin
                            w_phase_nxt    = PH_PIX_HI;
                            w_pix_addr_nxt = '0;
                            w_state_nxt    = ST_PIX_RD;
                        end else begin
                            w_rom_addr_nxt = r_rom_addr + ROM_AW'(1);
                            w_state_nxt    = ST_ROM_RD;
                        end
                    end
                    PH_PIX_HI: begin
                        w_spi_data_nxt = r_pix_lo;
                        w_spi_dc_nxt   = 1'b1;
                        w_spi_init_nxt = 1'b1;
                        w_armed_nxt    = 1'b0;
                        w_phase_nxt    = PH_PIX_LO;
                        w_state_nxt    = ST_SEND;
                    end
                    default: begin
                        if (r_pix_addr == PIX_AW'(NPIX - 1)) begin
                            w_frame_done_nxt = 1'b1;
`ifdef SCREEN_FEEDER_REFRESH_EN
                            w_pix_addr_nxt   = '0;
                            w_phase_nxt      = PH_PIX_HI;
                            w_state_nxt      = ST_PIX_RD;
`else
                            w_busy_nxt       = 1'b0;
                            w_state_nxt      = ST_IDLE;
`endif
                        end else begin
                            w_pix_addr_nxt = r_pix_addr + PIX_AW'(1);
                            w_phase_nxt    = PH_PIX_HI;
                            w_state_nxt    = ST_PIX_RD;
                        end
                    end
                endcase
            end
            ST_PIX_RD: begin
                w_spi_data_nxt = i_pix_data[PIX_W-1:BYTE_W];
                w_pix_lo_nxt   = i_pix_data[BYTE_W-1:0];
                w_spi_dc_nxt   = 1'b1;
                w_spi_init_nxt = 1'b1;
                w_armed_nxt    = 1'b0;
                w_phase_nxt    = PH_PIX_HI;
                w_state_nxt    = ST_SEND;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_rom_addr   = r_rom_addr;
    assign o_pix_addr   = r_pix_addr;
    assign o_spi_data   = r_spi_data;
    assign o_spi_dc     = r_spi_dc;
    assign o_spi_init   = r_spi_init;

endmodule
